// File: rtl/dataTypes_pkg.sv
// Shared types for the BRAM capture path: writer FSM states and the BRAM address mask.
package dataTypes_pkg;

    typedef enum logic [2:0] {
        s_idle,
        s_rstWait,
        s_load,
        s_write,
        s_done
    } bramWrite_t;

    localparam int unsigned BRAM_DEPTH_MAX = 32768;
    localparam logic [15:0] BRAM_ADDR_MASK = 16'(BRAM_DEPTH_MAX - 1);

endpackage

// File: rtl/bram_capture_writer_if.sv
// Capture stream (valid/ready) plus BRAM write port, seen from the writer as master.
interface bram_capture_writer_if #(
    parameter int BRAM_ADDR_SIZE = 15,
    parameter int BRAM_DATA_SIZE = 32
);
    logic [BRAM_DATA_SIZE-1:0] inData;
    logic                      inValid;
    logic                      inReady;
    logic                      resetBusy;
    logic [BRAM_ADDR_SIZE-1:0] addr;
    logic [BRAM_DATA_SIZE-1:0] writeData;
    logic                      bramEnable;
    logic                      bramWe;

    modport master (
        input  inData, inValid, resetBusy,
        output inReady, addr, writeData, bramEnable, bramWe
    );

    modport slave (
        output inData, inValid, resetBusy,
        input  inReady, addr, writeData, bramEnable, bramWe
    );
endinterface

// File: rtl/oneshot.sv
// Turns a level input into a single-cycle pulse on its rising edge.
module oneshot (
    input  logic clk,
    input  logic resetN,
    input  logic pulse,
    output logic oneShot
);
    logic pulse_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) pulse_d <= 1'b0;
        else         pulse_d <= pulse;
    end

    assign oneShot = pulse & ~pulse_d;
endmodule

// File: rtl/bram_capture_writer.sv
// Streams capture words into BRAM at sequential addresses from a base address.
// Define BRAM_WRITER_CIRCULAR_EN to wrap at the top of BRAM instead of stopping with overflow.
module bram_capture_writer
    import dataTypes_pkg::*;
#(
    parameter int BRAM_ADDR_SIZE = 15,
    parameter int BRAM_DATA_SIZE = 32,
    parameter int BRAM_DEPTH     = 32768
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] baseAddr,
    input  logic [15:0] numWrites,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] wordsWritten,
    bram_capture_writer_if.master bus
);
    localparam logic [BRAM_ADDR_SIZE-1:0] TOP_ADDR = BRAM_ADDR_SIZE'(BRAM_DEPTH - 1);

    bramWrite_t                state, state_nxt;
    logic                      startPulse;
    logic                      accept_p0;
    logic                      ovfSet;
    logic                      topHit;
    logic [15:0]               storedWrites;
    logic [15:0]               maskedBase;
    logic [BRAM_ADDR_SIZE-1:0] wrAddr;
    logic [BRAM_DATA_SIZE-1:0] capData_p0;
    logic                      unused_baseHi;

    oneshot u_startPulse (
        .clk     (clk),
        .resetN  (resetN),
        .pulse   (start),
        .oneShot (startPulse)
    );

    assign maskedBase    = baseAddr & BRAM_ADDR_MASK;
    assign unused_baseHi = ^maskedBase;

    // topHit stops intake once the last BRAM word has been taken, so the
    // FSM can close out with overflow while words are still outstanding.
    assign bus.inReady = (state == s_write) && (wordsWritten < storedWrites)
                         && !topHit && !abort;
    assign accept_p0   = bus.inValid && bus.inReady;
    assign capData_p0  = bus.inData;

    assign busy = (state != s_idle) && (state != s_done);
    assign done = (state == s_done);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= s_idle;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ovfSet    = 1'b0;
        if (abort) begin
            state_nxt = s_idle;
        end else begin
            case (state)
                s_idle:    if (startPulse) state_nxt = s_rstWait;
                s_rstWait: if (!bus.resetBusy) state_nxt = s_load;
                s_load:    state_nxt = (numWrites == 16'd0) ? s_done : s_write;
                s_write: begin
                    if (wordsWritten >= storedWrites) begin
                        state_nxt = s_done;
                    end else if (topHit) begin
                        state_nxt = s_done;
                        ovfSet    = 1'b1;
                    end
                end
                s_done:    if (startPulse) state_nxt = s_rstWait;
                default:   state_nxt = s_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrAddr       <= '0;
            storedWrites <= '0;
            wordsWritten <= '0;
            overflow     <= 1'b0;
            topHit       <= 1'b0;
        end else begin
            if (state == s_load && !abort) begin
                wrAddr       <= maskedBase[BRAM_ADDR_SIZE-1:0];
                storedWrites <= numWrites;
                wordsWritten <= '0;
                overflow     <= 1'b0;
                topHit       <= 1'b0;
            end
            if (ovfSet) overflow <= 1'b1;
            if (accept_p0) begin
                wordsWritten <= wordsWritten + 16'd1;
`ifdef BRAM_WRITER_CIRCULAR_EN
                wrAddr <= (wrAddr == TOP_ADDR) ? '0 : wrAddr + BRAM_ADDR_SIZE'(1);
`else
                wrAddr <= wrAddr + BRAM_ADDR_SIZE'(1);
                if (wrAddr == TOP_ADDR) topHit <= 1'b1;
`endif
            end
        end
    end

    // p0 -> p1: accepted word becomes a one-cycle BRAM write strobe
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.bramEnable <= 1'b0;
            bus.bramWe     <= 1'b0;
            bus.addr       <= '0;
            bus.writeData  <= '0;
        end else begin
            bus.bramEnable <= accept_p0;
            bus.bramWe     <= accept_p0;
            if (accept_p0) begin
                bus.addr      <= wrAddr;
                bus.writeData <= capData_p0;
            end
        end
    end

endmodule

// File: tb/tb_bram_capture_writer.sv
// Directed bench for bram_capture_writer: captures, backpressure, limits, abort and reset.
module tb_bram_capture_writer;
    import dataTypes_pkg::*;

    logic        clk;
    logic        resetN;
    logic        start;
    logic        abort;
    logic [15:0] baseAddr;
    logic [15:0] numWrites;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] wordsWritten;

    bram_capture_writer_if #(.BRAM_ADDR_SIZE(15), .BRAM_DATA_SIZE(32)) bus_if ();

    bram_capture_writer #(
        .BRAM_ADDR_SIZE (15),
        .BRAM_DATA_SIZE (32),
        .BRAM_DEPTH     (32768)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start        (start),
        .abort        (abort),
        .baseAddr     (baseAddr),
        .numWrites    (numWrites),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .wordsWritten (wordsWritten),
        .bus          (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_bad = 0;
    int hs_cyc[$];
    int wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetN) begin
            if (bus_if.inValid && bus_if.inReady) hs_cyc.push_back(cyc);
            if (bus_if.bramWe) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(32'(bus_if.addr));
                wr_data.push_back(bus_if.writeData);
                if (!bus_if.bramEnable) en_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        hs_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic begin_capture(input logic [15:0] base, input logic [15:0] n);
        baseAddr  = base;
        numWrites = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int c = 0;
        while (!bus_if.inReady && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_ready"}, 32'(bus_if.inReady), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Presents n words first, first+1, ...; with gaps, inValid toggles 1,0,1,0...
    task automatic stream(input string tag, input int n, input logic [31:0] first,
                          input bit gaps, input int budget);
        int idx = 0;
        int c = 0;
        while (idx < n && c < budget) begin
            bus_if.inValid = gaps ? ((c % 2) == 0) : 1'b1;
            bus_if.inData  = first + 32'(idx);
            @(negedge clk);
            if (bus_if.inValid && bus_if.inReady) idx++;
            tick();
            c++;
        end
        bus_if.inValid = 1'b0;
        check({tag, "_accepted"}, 32'(idx), 32'(n));
    endtask

    task automatic check_writes(input string tag, input logic [15:0] base,
                                input logic [31:0] data0, input int n);
        check({tag, "_nwrites"}, 32'(wr_cyc.size()), 32'(n));
        check({tag, "_nhs"}, 32'(hs_cyc.size()), 32'(n));
        for (int i = 0; i < n && i < wr_cyc.size() && i < hs_cyc.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'((32'(base) + 32'(i)) & 32'h7FFF));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], data0 + 32'(i));
            check($sformatf("%s_lat%0d", tag, i), 32'(wr_cyc[i] - hs_cyc[i]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN           = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        baseAddr         = '0;
        numWrites        = '0;
        bus_if.inData    = '0;
        bus_if.inValid   = 1'b0;
        bus_if.resetBusy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_inReady", 32'(bus_if.inReady), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_words", 32'(wordsWritten), 32'd0);
        check("rst_addr", 32'(bus_if.addr), 32'd0);
        check("rst_wdata", bus_if.writeData, 32'd0);
        check("rst_en", 32'(bus_if.bramEnable), 32'd0);
        check("rst_we", 32'(bus_if.bramWe), 32'd0);
        check("rst_state", 32'(dut.state), 32'(s_idle));
        @(negedge clk);
        resetN = 1'b1;
        tick();

        // Basic capture, back-to-back
        clear_log();
        begin_capture(16'h0100, 16'd4);
        wait_ready("basic", 20);
        stream("basic", 4, 32'hA0, 1'b0, 40);
        check("basic_ready_drop", 32'(bus_if.inReady), 32'd0);
        check("basic_busy_mid", 32'(busy), 32'd1);
        wait_done("basic", 10);
        check_writes("basic", 16'h0100, 32'hA0, 4);
        if (wr_cyc.size() == 4) check("basic_b2b", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
        check("basic_words", 32'(wordsWritten), 32'd4);
        check("basic_ovf", 32'(overflow), 32'd0);
        check("basic_inReady", 32'(bus_if.inReady), 32'd0);
        check("basic_busy", 32'(busy), 32'd0);
        check("basic_we_idle", 32'(bus_if.bramWe), 32'd0);
        check("basic_addr_hold", 32'(bus_if.addr), 32'h103);

        // Backpressure
        clear_log();
        begin_capture(16'h0200, 16'd3);
        wait_ready("bp", 20);
        stream("bp", 3, 32'hB0, 1'b1, 40);
        wait_done("bp", 10);
        check_writes("bp", 16'h0200, 32'hB0, 3);
        if (wr_cyc.size() == 3) check("bp_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
        check("bp_words", 32'(wordsWritten), 32'd3);

        // Zero length
        clear_log();
        begin_capture(16'h0300, 16'd0);
        wait_done("zero", 10);
        check("zero_words", 32'(wordsWritten), 32'd0);
        check("zero_nwrites", 32'(wr_cyc.size()), 32'd0);
        check("zero_ovf", 32'(overflow), 32'd0);

        // Top of memory
        clear_log();
        begin_capture(16'h7FFE, 16'd4);
        wait_ready("top", 20);
`ifdef BRAM_WRITER_CIRCULAR_EN
        stream("top", 4, 32'hC0, 1'b0, 40);
        wait_done("top", 10);
        check_writes("top", 16'h7FFE, 32'hC0, 4);
        check("top_ovf", 32'(overflow), 32'd0);
        check("top_words", 32'(wordsWritten), 32'd4);
`else
        stream("top", 2, 32'hC0, 1'b0, 40);
        check("top_ready_stop", 32'(bus_if.inReady), 32'd0);
        wait_done("top", 10);
        check_writes("top", 16'h7FFE, 32'hC0, 2);
        check("top_ovf", 32'(overflow), 32'd1);
        check("top_words", 32'(wordsWritten), 32'd2);
`endif

        // resetBusy holds off the capture
        clear_log();
        bus_if.resetBusy = 1'b1;
        begin_capture(16'h0400, 16'd2);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (bus_if.inReady) seen++;
                tick();
            end
            check("rbusy_noready", 32'(seen), 32'd0);
        end
        check("rbusy_state", 32'(dut.state), 32'(s_rstWait));
        bus_if.resetBusy = 1'b0;
        wait_ready("rbusy", 10);
        stream("rbusy", 2, 32'hE0, 1'b0, 20);
        wait_done("rbusy", 10);
        check_writes("rbusy", 16'h0400, 32'hE0, 2);

        // Abort after 2 of 8
        clear_log();
        begin_capture(16'h0500, 16'd8);
        wait_ready("abort", 20);
        stream("abort", 2, 32'hF0, 1'b0, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(dut.state), 32'(s_idle));
        check("abort_words", 32'(wordsWritten), 32'd2);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        check_writes("abort", 16'h0500, 32'hF0, 2);

        // abort beats a simultaneous start
        abort = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("abort_prio", 32'(dut.state), 32'(s_idle));

        // start held high across done
        clear_log();
        baseAddr  = 16'h0600;
        numWrites = 16'd1;
        start     = 1'b1;
        tick();
        wait_ready("hold", 20);
        stream("hold", 1, 32'hD0, 1'b0, 20);
        wait_done("hold", 10);
        repeat (5) tick();
        check("hold_done", 32'(done), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("hold_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_ready("hold2", 20);
        stream("hold2", 1, 32'hD8, 1'b0, 20);
        wait_done("hold2", 10);
        check("hold2_words", 32'(wordsWritten), 32'd1);

        // Async reset mid-capture
        clear_log();
        begin_capture(16'h0700, 16'd8);
        wait_ready("arst", 20);
        stream("arst", 5, 32'h50, 1'b0, 20);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_inReady", 32'(bus_if.inReady), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_words", 32'(wordsWritten), 32'd0);
        check("arst_addr", 32'(bus_if.addr), 32'd0);
        check("arst_wdata", bus_if.writeData, 32'd0);
        check("arst_en", 32'(bus_if.bramEnable), 32'd0);
        check("arst_we", 32'(bus_if.bramWe), 32'd0);
        check("arst_state", 32'(dut.state), 32'(s_idle));
        #10;
        resetN = 1'b1;
        tick();
        check("arst_after", 32'(busy), 32'd0);

        check("en_with_we", 32'(en_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_capture_writer.md
Name: bram_capture_writer

Overview:
- Write-side counterpart of the BRAM read/buffer controller.
- Accepts a valid/ready stream of 32-bit capture words and writes them into the shared BRAM at sequential addresses, starting at a requested base address.
- Reports progress and completion to the timing-analysis control FSM, which later reads the same region back.

Parameters:
- BRAM_ADDR_SIZE, 15, BRAM address width.
- BRAM_DATA_SIZE, 32, BRAM and stream data width.
- BRAM_DEPTH, 32768, number of BRAM words; highest valid address is BRAM_DEPTH-1.

Ports:
- clk  input  1  system clock.
- resetN  input  1  reset; asynchronous, active-low.
- start  input  1  level request; the internal rising-edge pulse begins a capture.
- abort  input  1  synchronous cancel, active-high.
- baseAddr  input  16  first write address; only the low BRAM_ADDR_SIZE bits are used.
- numWrites  input  16  number of words to capture.
- inData  input  BRAM_DATA_SIZE  stream data.
- inValid  input  1  stream valid.
- inReady  output  1  stream ready.
- busy  output  1  capture in progress (every state except s_idle and s_done).
- done  output  1  capture finished; level signal.
- overflow  output  1  capture ended at top of BRAM before numWrites was reached.
- wordsWritten  output  16  count of words committed to BRAM.
- resetBusy  input  1  BRAM reset-busy.
- addr  output  BRAM_ADDR_SIZE  BRAM address.
- writeData  output  BRAM_DATA_SIZE  BRAM write data.
- bramEnable  output  1  BRAM enable.
- bramWe  output  1  BRAM write enable.

Behaviour:
- Reset (async, resetN=0):
  - state=s_idle.
  - inReady, busy, done, overflow, bramEnable, bramWe all 0.
  - wordsWritten=0, addr=0, writeData=0.
- Start detection: a rising edge of start is turned into a one-cycle pulse.
  - Pulses in s_idle or s_done are accepted.
  - Pulses in any other state are ignored.
- FSM states: s_idle, s_rstWait, s_load, s_write, s_done.
- s_idle: on start pulse, go to s_rstWait.
- s_rstWait: stay while resetBusy=1, else go to s_load.
- s_load (one cycle):
  - Latch baseAddr and numWrites into internal registers.
  - Clear wordsWritten, done and overflow.
  - If latched numWrites=0, go to s_done; otherwise go to s_write.
- s_write:
  - inReady=1 while wordsWritten < storedWrites.
  - A handshake (inValid && inReady) in cycle N drives, in cycle N+1, bramEnable=1, bramWe=1, addr=current write address, writeData=inData. These strobes last exactly one cycle per word.
  - wordsWritten increments in cycle N+1.
  - Back-to-back handshakes give one write per cycle, i.e. throughput 1 word/clk.
- Address progression: the write address increments by 1 after each write.
- Termination condition A: the last word (wordsWritten reaches storedWrites) has been written. Go to s_done; inReady drops in the cycle after the final handshake.
- Termination condition B: the address BRAM_DEPTH-1 has been written and words remain. Go to s_done with overflow=1; the macro changes this case (see Optional Feature).
- s_done:
  - done=1; wordsWritten and overflow held.
  - A start pulse goes to s_rstWait and begins a new capture.
- abort:
  - In any state, go to s_idle next cycle.
  - A write strobe already registered for that cycle still completes.
  - wordsWritten is held; done stays 0.
  - abort has priority over a simultaneous start.
- Outside write strobes, bramEnable and bramWe are 0; addr and writeData hold their last value.
- Arithmetic: counters are 16-bit unsigned. The comparison against storedWrites is unsigned. Address arithmetic is BRAM_ADDR_SIZE bits wide.

Optional Feature:
- Macro: BRAM_WRITER_CIRCULAR_EN.
- Defined: when BRAM_DEPTH-1 is written and words remain, the address wraps to 0 and capture continues until numWrites. overflow stays 0. wordsWritten still counts all words.
- Undefined: behaviour is termination condition B in Behaviour.

Decomposition:
- Shared package dataTypes_pkg gets:
  - the state typedef bramWrite_t (enum logic [2:0]);
  - a constant for the valid address mask.
- The rising-edge pulse on start reuses the existing oneshot module (pulse=start). No other sub-module.

Test Plan:
- Basic capture: baseAddr=0x0100, numWrites=4, inValid held high with words 0xA0..0xA3. Expected:
  - four consecutive strobes at addr 0x100..0x103;
  - wordsWritten=4, done=1, overflow=0;
  - inReady=0 afterwards.
- Backpressure: numWrites=3 with inValid toggling 1,0,1,0,1. Expected:
  - exactly 3 strobes, each one cycle after its handshake;
  - no strobe in gap cycles.
- Zero length: numWrites=0. Expected: done=1 after s_load, no bramWe pulse, wordsWritten=0.
- Top of memory: baseAddr=0x7FFE, numWrites=4.
  - Macro undefined: writes at 0x7FFE and 0x7FFF, then done=1, overflow=1, wordsWritten=2.
  - Macro defined: writes at 0x7FFE, 0x7FFF, 0x0000, 0x0001; overflow=0.
- resetBusy and abort:
  - resetBusy high for 10 cycles after start: no inReady until it falls.
  - abort after 2 of 8 words: s_idle, wordsWritten=2, done=0.
  - start held high across done: no restart until start falls and rises again.
- Async reset mid-capture: drop resetN after 5 words. Expected: all outputs return to reset values immediately, without waiting for a clock edge.
